lstm_cell_seq: RTL and testbench
================================

Name: lstm_cell_seq

Overview:
- Parametrised multi-unit LSTM cell sequencer; successor to the single-unit gate controller.
- Per timestep, consumes 4*N_HID gate pre-activations from the MAC array over a valid/ready stream.
- Applies PWL sigmoid/tanh, updates an internal per-unit cell-state file, and emits N_HID hidden outputs over a valid/ready stream.
- Sits between the FloatSD8 MAC array and the next-layer input buffer.

Parameters:
- DW, 16, signed fixed-point data width for pre-activations, c and h.
- FW, 12, fractional bits; 1.0 = 2^FW (4096 at default).
- N_HID, 4, hidden units per timestep (>=1).
- CELL_CLIP, 3*2^FW, symmetric cell-state clip magnitude (used only with CELL_CLIP_EN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a timestep; accepted only in IDLE
- clr_state  in  1  zero all stored c in IDLE
- pre_valid  in  1  pre-activation valid
- pre_ready  out  1  block accepts pre-activation
- pre_data  in  DW  signed pre-activation (bias already added)
- h_valid  out  1  hidden output valid
- h_ready  in  1  downstream accepts h
- h_data  out  DW  signed hidden output
- h_idx  out  clog2(N_HID) (min 1)  unit index of h_data
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse after the last unit's h handshake

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state IDLE; all c[k]=0; pre_ready=0, h_valid=0, h_data=0, h_idx=0, busy=0, done=0; unit counter u=0.
- Reset mid-operation: abort immediately. Partial-unit results are discarded and the c file is zeroed.
- States: IDLE, G_F, G_I, G_G, G_O, C_UPD, H_UPD, H_OUT.
- IDLE:
  - start=1: go to G_F, u=0.
  - clr_state=1 with start=0: zero all c[k] in one cycle.
  - start and clr_state both high: clear first, then start (c=0 used for the timestep).
  - start and clr_state are ignored outside IDLE.
- Gate capture: pre_ready=1 only in G_F/G_I/G_G/G_O. Each pre_valid&pre_ready handshake captures one gate, then advances to the next state.
  - Order per unit: F, I, G, O.
  - F, I, O captures: hsig(x) = clamp((x>>>2) + 2^(FW-1), 0, 2^FW).
  - G capture: htanh(x) = clamp(x, -2^FW, 2^FW).
  - Stalls without limit while pre_valid=0.
- C_UPD (1 cycle): c_new = sat(((f*c[u])>>>FW) + ((i*g)>>>FW)).
  - Products are full 2*DW; arithmetic shift floors.
  - The sum saturates to the signed DW range. Write c[u] <= c_new.
- H_UPD (1 cycle): h = sat((o*htanh(c[u]))>>>FW). Register h_data=h, h_idx=u, h_valid=1.
- H_OUT: hold h_valid, h_data and h_idx stable until h_ready. On handshake, h_valid=0, then:
  - if u<N_HID-1: u++, go to G_F;
  - else pulse done, u=0, go to IDLE.
- Minimum latency per unit: 4 gate cycles + C_UPD + H_UPD + 1 output cycle = 7 cycles. Timestep minimum = 7*N_HID, then done.
- c persists across timesteps until rst or clr_state.
- The h/c state file is internal; h_prev feedback is the consumer's job.

Optional Feature:
- Macro: CELL_CLIP_EN.
- Defined: c_new is additionally clamped to [-CELL_CLIP, +CELL_CLIP] before the write, and sticky output clip_flag (1 bit) is added. clip_flag sets when any clamp engages and clears on rst or clr_state.
- Undefined: no clamp beyond DW saturation, and the clip_flag port is absent.

Decomposition:
- Package lstm_pkg:
  - constants DW_DEF, FW_DEF, ONE_Q = 2^FW, HALF_Q;
  - state enum lstm_st_t;
  - gate index enum {GATE_F, GATE_I, GATE_G, GATE_O};
  - sat_dw function.
- Sub-module lstm_act_pwl (combinational): hsig and htanh with a mode select. Instantiated once for gate capture and once for htanh(c).

Test Plan:
- rst; start; per unit stream F=0, I=0, G=4096, O=32767 with c=0 -> each h_data=2048 and c[k]=2048. done pulses once after h_idx=3.
- Second timestep, same stream, no clear -> c[k]=3072, h_data=3072. Then clr_state in IDLE and a third timestep -> h_data=2048 again.
- Saturation: F=8192 (f=4096), I=8192, G=-32768 (g=-4096), c[u]=-32768 -> c_new saturates to -32768. With O=8192, h_data=-4096.
- Backpressure:
  - pre_valid random 30% duty -> results unchanged, no capture while pre_ready=0.
  - h_ready low 10 cycles -> h_data/h_idx stable, pre_ready=0 throughout.
- rst asserted during G_G of unit 2 -> next cycle IDLE, all outputs at reset values. A following timestep behaves as from c=0. start held during busy is ignored.
- CELL_CLIP_EN: F=I=8192, G=8192, c[u]=12000 -> c_new clamped to 12288 (CELL_CLIP) only after exceeding; clip_flag=1 and sticky until clr_state.

Source files
------------

// File: rtl/lstm_pkg.sv
// Shared types and constants for the multi-unit LSTM cell sequencer.
// Holds the FSM state enum, the gate-index and activation-mode enums, and the DW saturation helper.
package lstm_pkg;

    localparam int DW_DEF = 16;
    localparam int FW_DEF = 12;
    localparam int ONE_Q  = 1 << FW_DEF;
    localparam int HALF_Q = ONE_Q / 2;

    typedef enum logic [2:0] {
        IDLE,
        G_F,
        G_I,
        G_G,
        G_O,
        C_UPD,
        H_UPD,
        H_OUT
    } lstm_st_t;

    typedef enum logic [1:0] {
        GATE_F,
        GATE_I,
        GATE_G,
        GATE_O
    } gate_t;

    typedef enum logic {
        ACT_SIG,
        ACT_TANH
    } act_mode_t;

    // Clamp a wide signed value into the signed range of a dw-bit word.
    function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v, input int unsigned dw);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (v > max_v) begin
            return max_v;
        end
        if (v < min_v) begin
            return min_v;
        end
        return v;
    endfunction

endpackage

// File: rtl/lstm_cell_seq_if.sv
// Pre-activation input stream and hidden-output stream of the LSTM cell sequencer.
// The master side is the MAC array / consumer environment; the slave side is the sequencer.
interface lstm_cell_seq_if
    import lstm_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int IW = 2
);

    logic                 pre_valid;
    logic                 pre_ready;
    logic signed [DW-1:0] pre_data;
    logic                 h_valid;
    logic                 h_ready;
    logic signed [DW-1:0] h_data;
    logic [IW-1:0]        h_idx;

    modport master (
        output pre_valid, pre_data, h_ready,
        input  pre_ready, h_valid, h_data, h_idx
    );

    modport slave (
        input  pre_valid, pre_data, h_ready,
        output pre_ready, h_valid, h_data, h_idx
    );

endinterface

// File: rtl/lstm_act_pwl.sv
// Piecewise-linear activations: hard sigmoid clamp((x>>>2)+0.5, 0, 1) or hard tanh clamp(x, -1, 1).
// Purely combinational; the internal word is two bits wider so the offset add cannot wrap.
module lstm_act_pwl
    import lstm_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int FW = FW_DEF
) (
    input  act_mode_t            mode,
    input  logic signed [DW-1:0] x,
    output logic signed [DW-1:0] y
);

    localparam logic signed [DW+1:0] ONE_W  = (DW+2)'(1 << FW);
    localparam logic signed [DW+1:0] HALF_W = (DW+2)'(1 << (FW - 1));

    logic signed [DW+1:0] xe;
    logic signed [DW+1:0] t;
    logic signed [DW+1:0] lo;
    logic signed [DW+1:0] r;

    always_comb begin
        xe = (DW+2)'(x);
        t  = xe;
        lo = -ONE_W;
        if (mode == ACT_SIG) begin
            t  = (xe >>> 2) + HALF_W;
            lo = '0;
        end
        if (t < lo) begin
            r = lo;
        end else if (t > ONE_W) begin
            r = ONE_W;
        end else begin
            r = t;
        end
        y = DW'(r);
    end

endmodule

// File: rtl/lstm_cell_seq.sv
// Multi-unit LSTM cell sequencer: captures F/I/G/O per unit, updates the internal c file, emits h per unit.
// Optional macro CELL_CLIP_EN adds a symmetric cell-state clamp and a sticky clip_flag output.
module lstm_cell_seq
    import lstm_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int FW    = FW_DEF,
    parameter int N_HID = 4
`ifdef CELL_CLIP_EN
    ,
    parameter int CELL_CLIP = 3 * (1 << FW)
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clr_state,
    lstm_cell_seq_if.slave    io,
    output logic              busy,
    output logic              done
`ifdef CELL_CLIP_EN
    ,
    output logic              clip_flag
`endif
);

    localparam int IW = (N_HID > 1) ? $clog2(N_HID) : 1;

    lstm_st_t state_q;
    lstm_st_t state_d;
    gate_t    cur_gate;

    logic [IW-1:0]        u_q;
    logic signed [DW-1:0] f_q;
    logic signed [DW-1:0] i_q;
    logic signed [DW-1:0] g_q;
    logic signed [DW-1:0] o_q;
    logic signed [DW-1:0] c_mem [N_HID];

    logic                 pre_ready_c;
    logic                 pre_hs;
    logic                 last_unit;
    act_mode_t            gate_mode;
    logic signed [DW-1:0] gate_act;
    logic signed [DW-1:0] c_cur;
    logic signed [DW-1:0] c_tanh;

    logic signed [2*DW-1:0] fc_prod;
    logic signed [2*DW-1:0] ig_prod;
    logic signed [2*DW-1:0] oh_prod;
    logic signed [63:0]     c_sum;
    logic signed [63:0]     c_sat;
    logic signed [63:0]     c_lim;
    logic signed [63:0]     h_sat;
    logic signed [DW-1:0]   c_new;
    logic signed [DW-1:0]   h_new;
    logic                   clip_hit;

    assign io.pre_ready = pre_ready_c;
    assign pre_hs       = io.pre_valid & pre_ready_c;
    assign last_unit    = (u_q == IW'(N_HID - 1));
    assign c_cur        = c_mem[u_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pre_ready_c = 1'b0;
        busy        = (state_q != IDLE);
        cur_gate    = GATE_F;
        gate_mode   = ACT_SIG;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = G_F;
            end
            G_F: begin
                pre_ready_c = 1'b1;
                if (pre_hs) state_d = G_I;
            end
            G_I: begin
                pre_ready_c = 1'b1;
                cur_gate    = GATE_I;
                if (pre_hs) state_d = G_G;
            end
            G_G: begin
                pre_ready_c = 1'b1;
                cur_gate    = GATE_G;
                gate_mode   = ACT_TANH;
                if (pre_hs) state_d = G_O;
            end
            G_O: begin
                pre_ready_c = 1'b1;
                cur_gate    = GATE_O;
                if (pre_hs) state_d = C_UPD;
            end
            C_UPD: state_d = H_UPD;
            H_UPD: state_d = H_OUT;
            H_OUT: begin
                if (io.h_ready) state_d = last_unit ? IDLE : G_F;
            end
            default: state_d = IDLE;
        endcase
    end

    lstm_act_pwl #(.DW(DW), .FW(FW)) u_gate_act (
        .mode (gate_mode),
        .x    (io.pre_data),
        .y    (gate_act)
    );

    lstm_act_pwl #(.DW(DW), .FW(FW)) u_cell_act (
        .mode (ACT_TANH),
        .x    (c_cur),
        .y    (c_tanh)
    );

    // Full-width products, floor shift back to Q(FW), then saturate (and optionally clip) to DW.
    always_comb begin
        fc_prod  = f_q * c_cur;
        ig_prod  = i_q * g_q;
        c_sum    = 64'(fc_prod >>> FW) + 64'(ig_prod >>> FW);
        c_sat    = sat_dw(c_sum, DW);
        c_lim    = c_sat;
        clip_hit = 1'b0;
`ifdef CELL_CLIP_EN
        if (c_sat > 64'(CELL_CLIP)) begin
            c_lim    = 64'(CELL_CLIP);
            clip_hit = 1'b1;
        end else if (c_sat < -64'(CELL_CLIP)) begin
            c_lim    = -64'(CELL_CLIP);
            clip_hit = 1'b1;
        end
`endif
        c_new   = DW'(c_lim);
        oh_prod = o_q * c_tanh;
        h_sat   = sat_dw(64'(oh_prod >>> FW), DW);
        h_new   = DW'(h_sat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            u_q        <= '0;
            f_q        <= '0;
            i_q        <= '0;
            g_q        <= '0;
            o_q        <= '0;
            io.h_valid <= 1'b0;
            io.h_data  <= '0;
            io.h_idx   <= '0;
            done       <= 1'b0;
            for (int k = 0; k < N_HID; k++) c_mem[k] <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (clr_state) begin
                        for (int k = 0; k < N_HID; k++) c_mem[k] <= '0;
                    end
                    if (start) u_q <= '0;
                end
                G_F, G_I, G_G, G_O: begin
                    if (pre_hs) begin
                        unique case (cur_gate)
                            GATE_F: f_q <= gate_act;
                            GATE_I: i_q <= gate_act;
                            GATE_G: g_q <= gate_act;
                            GATE_O: o_q <= gate_act;
                            default: ;
                        endcase
                    end
                end
                C_UPD: c_mem[u_q] <= c_new;
                H_UPD: begin
                    io.h_data  <= h_new;
                    io.h_idx   <= u_q;
                    io.h_valid <= 1'b1;
                end
                H_OUT: begin
                    if (io.h_ready) begin
                        io.h_valid <= 1'b0;
                        if (last_unit) begin
                            done <= 1'b1;
                            u_q  <= '0;
                        end else begin
                            u_q <= u_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CELL_CLIP_EN
    // Sticky until an explicit clear; only an update that actually clamps sets it.
    always_ff @(posedge clk) begin
        if (rst) begin
            clip_flag <= 1'b0;
        end else if (state_q == IDLE && clr_state) begin
            clip_flag <= 1'b0;
        end else if (state_q == C_UPD && clip_hit) begin
            clip_flag <= 1'b1;
        end
    end
`else
    logic unused_clip;
    assign unused_clip = clip_hit;
`endif

endmodule

// File: tb/tb_lstm_cell_seq.sv
// Directed self-checking bench for lstm_cell_seq with hand-computed h values per timestep.
// Expected values for the saturation probes differ when CELL_CLIP_EN is defined.
module tb_lstm_cell_seq;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic clr_state;
    logic busy;
    logic done;
`ifdef CELL_CLIP_EN
    logic clip_flag;
`endif

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    lstm_cell_seq_if #(.DW(16), .IW(2)) bus ();

    lstm_cell_seq #(.DW(16), .FW(12), .N_HID(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clr_state (clr_state),
        .io        (bus.slave),
        .busy      (busy),
        .done      (done)
`ifdef CELL_CLIP_EN
        ,
        .clip_flag (clip_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic flagTimeout(input string tag);
        total_cnt++;
        fail_cnt++;
        $error("[TB] FAIL %s timeout waiting on DUT", tag);
    endtask

    // Presents one gate value and returns at the negedge after its handshake.
    task automatic sendGate(input logic signed [15:0] x, input bit gap);
        int n;
        if (gap) begin
            for (int k = 0; k < 20 && $urandom_range(0, 99) >= 30; k++) @(negedge clk);
        end
        bus.pre_valid = 1'b1;
        bus.pre_data  = x;
        n = 0;
        while (!bus.pre_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.pre_ready) flagTimeout("pre_ready");
        @(negedge clk);
        bus.pre_valid = 1'b0;
        bus.pre_data  = 16'sh7fff;
    endtask

    task automatic recvH(input logic signed [15:0] exp_h, input int idx, input bit last, input int hold);
        int n;
        n = 0;
        while (!bus.h_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.h_valid) flagTimeout("h_valid");
        for (int k = 0; k < hold; k++) begin
            checkOutput("hold_h_data", bus.h_data, exp_h);
            checkOutput("hold_h_idx", bus.h_idx, idx);
            checkOutput("hold_pre_ready", bus.pre_ready, 0);
            @(negedge clk);
        end
        checkOutput("h_data", bus.h_data, exp_h);
        checkOutput("h_idx", bus.h_idx, idx);
        bus.h_ready = 1'b1;
        @(negedge clk);
        bus.h_ready = 1'b0;
        checkOutput("h_valid_drop", bus.h_valid, 0);
        checkOutput("done", done, last);
        if (last) begin
            @(negedge clk);
            checkOutput("done_single", done, 0);
            checkOutput("idle_after_done", busy, 0);
        end
    endtask

    task automatic applyStimulus(input logic signed [15:0] fx, input logic signed [15:0] ix,
                                 input logic signed [15:0] gx, input logic signed [15:0] ox,
                                 input logic signed [15:0] exp_h, input bit clr, input bit gap,
                                 input int hold, input bit poke);
        start     = 1'b1;
        clr_state = clr;
        @(negedge clk);
        start     = 1'b0;
        clr_state = 1'b0;
        checkOutput("busy_start", busy, 1);
        for (int u = 0; u < 4; u++) begin
            sendGate(fx, gap);
            if (poke && u == 1) begin
                start = 1'b1;
                clr_state = 1'b1;
                @(negedge clk);
                start = 1'b0;
                clr_state = 1'b0;
            end
            sendGate(ix, gap);
            sendGate(gx, gap);
            sendGate(ox, gap);
            recvH(exp_h, u, u == 3, (u == 2) ? hold : 0);
        end
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        clr_state     = 1'b0;
        bus.pre_valid = 1'b0;
        bus.pre_data  = '0;
        bus.h_ready   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_pre_ready", bus.pre_ready, 0);
        checkOutput("rst_h_valid", bus.h_valid, 0);
        checkOutput("rst_h_data", bus.h_data, 0);
        checkOutput("rst_h_idx", bus.h_idx, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        @(negedge clk);

        $display("[TB] timestep from c=0 and accumulation");
        applyStimulus(16'sd0, 16'sd0, 16'sd4096, 16'sd32767, 16'sd2048, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(16'sd0, 16'sd0, 16'sd4096, 16'sd32767, 16'sd3072, 1'b0, 1'b1, 0, 1'b0);

        $display("[TB] clr_state, output hold and ignored start");
        clr_state = 1'b1;
        @(negedge clk);
        clr_state = 1'b0;
        applyStimulus(16'sd0, 16'sd0, 16'sd4096, 16'sd32767, 16'sd2048, 1'b0, 1'b0, 10, 1'b1);

        $display("[TB] reset during G_G of unit 2");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int u = 0; u < 2; u++) begin
            sendGate(16'sd0, 1'b0);
            sendGate(16'sd0, 1'b0);
            sendGate(16'sd4096, 1'b0);
            sendGate(16'sd32767, 1'b0);
            recvH(16'sd3072, u, 1'b0, 0);
        end
        sendGate(16'sd0, 1'b0);
        sendGate(16'sd0, 1'b0);
        checkOutput("in_g_g", bus.pre_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_pre_ready", bus.pre_ready, 0);
        checkOutput("abort_h_valid", bus.h_valid, 0);
        checkOutput("abort_h_data", bus.h_data, 0);
        checkOutput("abort_h_idx", bus.h_idx, 0);
        checkOutput("abort_done", done, 0);
        applyStimulus(16'sd0, 16'sd0, 16'sd4096, 16'sd32767, 16'sd2048, 1'b0, 1'b0, 0, 1'b0);

        $display("[TB] cell-state saturation");
        for (int s = 0; s < 9; s++) begin
            applyStimulus(16'sd8192, 16'sd8192, -16'sd32768, 16'sd8192, -16'sd4096, s == 0, 1'b0, 0, 1'b0);
        end
`ifdef CELL_CLIP_EN
        checkOutput("clip_after_sat", clip_flag, 1);
        applyStimulus(16'sd0, 16'sd8192, 16'sd8192, 16'sd8192, -16'sd2048, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(16'sd0, 16'sd8192, 16'sd8192, 16'sd8192, 16'sd3072, 1'b0, 1'b0, 0, 1'b0);
`else
        applyStimulus(16'sd0, 16'sd8192, 16'sd8192, 16'sd8192, -16'sd4096, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus(16'sd0, 16'sd8192, 16'sd8192, 16'sd8192, -16'sd2048, 1'b0, 1'b0, 0, 1'b0);
`endif

`ifdef CELL_CLIP_EN
        $display("[TB] cell clip");
        clr_state = 1'b1;
        @(negedge clk);
        clr_state = 1'b0;
        checkOutput("clip_cleared", clip_flag, 0);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(16'sd8192, 16'sd8192, 16'sd8192, 16'sd8192, 16'sd4096, 1'b0, 1'b0, 0, 1'b0);
            checkOutput("clip_not_yet", clip_flag, 0);
        end
        applyStimulus(16'sd8192, 16'sd8192, 16'sd8192, 16'sd8192, 16'sd4096, 1'b0, 1'b0, 0, 1'b0);
        checkOutput("clip_set", clip_flag, 1);
        applyStimulus(16'sd0, 16'sd0, 16'sd0, 16'sd8192, 16'sd4096, 1'b0, 1'b0, 0, 1'b0);
        checkOutput("clip_sticky", clip_flag, 1);
        clr_state = 1'b1;
        @(negedge clk);
        clr_state = 1'b0;
        checkOutput("clip_clr", clip_flag, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
